otter_sa_cache: RTL and testbench

OTTER_SA_CACHE -- requirements
Module: otter_sa_cache

---
 rtl/otter_sa_cache.sv | 186 ++++++++++++++++++
 tb/tb_otter_sa_cache.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/otter_sa_cache.sv
// otter_sa_cache -- write-back, write-allocate, set-associative cache with
// true-LRU replacement and whole-line memory transfers.
//
// Parameters: WAYS (1..8), SETS (2..256), LINE_WORDS (2..16), all powers of two.
// Ports:
//   CLK, RST_N                  clock, asynchronous active-low reset
//   cpu_req/we/be/addr/wdata    CPU access, held stable until cpu_ready
//   cpu_ready, cpu_rdata        one-cycle completion pulse and load data
//   mem_req/we/addr/wdata       line transfer (we=1 writeback, 0 refill)
//   mem_ack, mem_rdata          transfer completion and refill line
// Optional build macro CACHE_STATS_EN adds hit_count / miss_count outputs.
module otter_sa_cache #(
   parameter int WAYS       = 2,
   parameter int SETS       = 8,
   parameter int LINE_WORDS = 8
) (
   input  logic                    CLK,
   input  logic                    RST_N,
   input  logic                    cpu_req,
   input  logic                    cpu_we,
   input  logic [3:0]              cpu_be,
   input  logic [31:0]             cpu_addr,
   input  logic [31:0]             cpu_wdata,
   output logic                    cpu_ready,
   output logic [31:0]             cpu_rdata,
   output logic                    mem_req,
   output logic                    mem_we,
   output logic [31:0]             mem_addr,
   output logic [32*LINE_WORDS-1:0] mem_wdata,
   input  logic                    mem_ack,
`ifdef CACHE_STATS_EN
   output logic [31:0]             hit_count,
   output logic [31:0]             miss_count,
`endif
   input  logic [32*LINE_WORDS-1:0] mem_rdata
);

   localparam int OB = $clog2(LINE_WORDS);
   localparam int IB = $clog2(SETS);
   localparam int TW = 32 - OB - IB - 2;
   localparam int AW = (WAYS > 1) ? $clog2(WAYS) : 1;

   typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;

   state_t state_q, state_d;

   logic [SETS-1:0] valid_q [WAYS];
   logic [SETS-1:0] dirty_q [WAYS];
   logic [AW-1:0]   age_q   [WAYS][SETS];
   logic [TW-1:0]   tag_q   [WAYS][SETS];
   logic [31:0]     data_q  [WAYS][SETS][LINE_WORDS];

   logic [OB-1:0] off;
   logic [IB-1:0] idx;
   logic [TW-1:0] tag;
   logic          hit, vic_found, lookup, refilled_q;
   logic [AW-1:0] hit_way, vic, victim_q;
   logic          unused_addr_bits;

   assign off = cpu_addr[OB+1:2];
   assign idx = cpu_addr[OB+IB+1:OB+2];
   assign tag = cpu_addr[31:OB+IB+2];
   assign unused_addr_bits = ^cpu_addr[1:0];

   // The cycle carrying cpu_ready still sees the old request held high, so
   // it must not start another lookup.
   assign lookup = (state_q == IDLE) && cpu_req && !cpu_ready;

   always_comb begin
      hit       = 1'b0;
      hit_way   = '0;
      vic       = '0;
      vic_found = 1'b0;
      for (int unsigned w = 0; w < WAYS; w++) begin
         if (valid_q[w][idx] && (tag_q[w][idx] == tag)) begin
            hit     = 1'b1;
            hit_way = AW'(w);
         end
      end
      for (int unsigned w = 0; w < WAYS; w++) begin
         if (!vic_found && !valid_q[w][idx]) begin
            vic       = AW'(w);
            vic_found = 1'b1;
         end
      end
      if (!vic_found) begin
         for (int unsigned w = 0; w < WAYS; w++) begin
            if (age_q[w][idx] == AW'(WAYS-1)) vic = AW'(w);
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      for (int unsigned i = 0; i < LINE_WORDS; i++)
         mem_wdata[32*i +: 32] = data_q[victim_q][idx][i];
      case (state_q)
         IDLE: begin
            if (lookup && !hit)
               state_d = (valid_q[vic][idx] && dirty_q[vic][idx]) ? WRITEBACK : REFILL;
         end
         WRITEBACK: begin
            mem_req  = 1'b1;
            mem_we   = 1'b1;
            mem_addr = {tag_q[victim_q][idx], idx, {(OB+2){1'b0}}};
            if (mem_ack) state_d = REFILL;
         end
         REFILL: begin
            mem_req  = 1'b1;
            mem_addr = {cpu_addr[31:OB+2], {(OB+2){1'b0}}};
            if (mem_ack) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cpu_ready  <= 1'b0;
         cpu_rdata  <= '0;
         victim_q   <= '0;
         refilled_q <= 1'b0;
         for (int unsigned w = 0; w < WAYS; w++) begin
            valid_q[w] <= '0;
            dirty_q[w] <= '0;
            for (int unsigned s = 0; s < SETS; s++) age_q[w][s] <= AW'(w);
         end
      end else begin
         cpu_ready <= 1'b0;
         if (lookup && hit) begin
            cpu_ready  <= 1'b1;
            cpu_rdata  <= data_q[hit_way][idx][off];
            refilled_q <= 1'b0;
            if (cpu_we) dirty_q[hit_way][idx] <= 1'b1;
            // Ages stay a permutation: only ways younger than the hit way age.
            for (int unsigned w = 0; w < WAYS; w++) begin
               if (AW'(w) == hit_way)
                  age_q[w][idx] <= '0;
               else if (age_q[w][idx] < age_q[hit_way][idx])
                  age_q[w][idx] <= age_q[w][idx] + 1'b1;
            end
         end
         if (lookup && !hit) victim_q <= vic;
         if ((state_q == REFILL) && mem_ack) begin
            valid_q[victim_q][idx] <= 1'b1;
            dirty_q[victim_q][idx] <= 1'b0;
            refilled_q             <= 1'b1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (lookup && hit && cpu_we) begin
         for (int unsigned b = 0; b < 4; b++)
            if (cpu_be[b]) data_q[hit_way][idx][off][8*b +: 8] <= cpu_wdata[8*b +: 8];
      end
      if ((state_q == REFILL) && mem_ack) begin
         for (int unsigned i = 0; i < LINE_WORDS; i++)
            data_q[victim_q][idx][i] <= mem_rdata[32*i +: 32];
         tag_q[victim_q][idx] <= tag;
      end
   end

`ifdef CACHE_STATS_EN
   // The lookup that completes a refilled access is not a fresh access.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else if (lookup) begin
         if (hit && !refilled_q) hit_count  <= hit_count + 32'd1;
         else if (!hit)          miss_count <= miss_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_otter_sa_cache.sv
// tb_otter_sa_cache -- scoreboard bench for otter_sa_cache (2 ways, 8 sets,
// 8-word lines). A recency-list cache model over a flat memory predicts
// load data, hit/miss latency and every line transfer.
module tb_otter_sa_cache;
   localparam int WAYS = 2;
   localparam int SETS = 8;
   localparam int LW   = 8;

   logic            CLK = 1'b0;
   logic            RST_N = 1'b0;
   logic            cpu_req = 1'b0, cpu_we = 1'b0;
   logic [3:0]      cpu_be = 4'h0;
   logic [31:0]     cpu_addr = '0, cpu_wdata = '0;
   logic            cpu_ready;
   logic [31:0]     cpu_rdata;
   logic            mem_req, mem_we;
   logic [31:0]     mem_addr;
   logic [32*LW-1:0] mem_wdata;
   logic            mem_ack = 1'b0;
   logic [32*LW-1:0] mem_rdata = '0;
`ifdef CACHE_STATS_EN
   logic [31:0]     hit_count, miss_count;
`endif

   otter_sa_cache #(.WAYS(WAYS), .SETS(SETS), .LINE_WORDS(LW)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack),
`ifdef CACHE_STATS_EN
      .hit_count(hit_count), .miss_count(miss_count),
`endif
      .mem_rdata(mem_rdata)
   );

   always #5 CLK = ~CLK;

   int unsigned cyc = 0;
   always @(posedge CLK) cyc++;

   int checks = 0;
   int errors = 0;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", nm, act, exp);
      end
   endtask

   typedef struct {
      bit          load;
      logic [31:0] rdata;
      bit          hit;
      int unsigned issue;
   } cpu_exp_t;
   typedef struct {
      bit           we;
      logic [31:0]  addr;
      logic [32*LW-1:0] line;
   } mem_exp_t;
   cpu_exp_t cpu_q[$];
   mem_exp_t mem_q[$];

   // Reference model: physical memory, CPU-visible memory, per-set recency lists.
   logic [31:0] pmem[int unsigned];
   logic [31:0] vmem[int unsigned];
   int unsigned lru[SETS][$];
   bit          dirty_ln[int unsigned];
   int unsigned m_hits = 0, m_miss = 0;
   bit          hold_ack = 1'b0;
   int unsigned dly = 0;

   function automatic logic [31:0] dflt(int unsigned wa);
      return (wa * 32'h9E3779B1) ^ 32'h5A5A0000;
   endfunction
   function automatic logic [31:0] prd(int unsigned wa);
      return pmem.exists(wa) ? pmem[wa] : dflt(wa);
   endfunction
   function automatic logic [31:0] vrd(int unsigned wa);
      return vmem.exists(wa) ? vmem[wa] : dflt(wa);
   endfunction
   function automatic logic [32*LW-1:0] vline(int unsigned la);
      logic [32*LW-1:0] l;
      for (int i = 0; i < LW; i++) l[32*i +: 32] = vrd((la >> 2) + i);
      return l;
   endfunction

   task automatic model_reset();
      for (int s = 0; s < SETS; s++) lru[s].delete();
      dirty_ln.delete();
      vmem.delete();
      foreach (pmem[k]) vmem[k] = pmem[k];
      m_hits = 0;
      m_miss = 0;
      cpu_q.delete();
      mem_q.delete();
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RST_N = 1'b0;
      cpu_req = 1'b0;
      #1;
      chk("rst_cpu_ready", {31'b0, cpu_ready}, 32'd0);
      chk("rst_cpu_rdata", cpu_rdata, 32'd0);
      chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
      chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      repeat (2) @(negedge CLK);
      model_reset();
      RST_N = 1'b1;
   endtask

   task automatic access(bit we, logic [3:0] be, logic [31:0] addr, logic [31:0] wd);
      int unsigned line, set, wa, n, v;
      int pos;
      logic [31:0] w;
      cpu_exp_t ce;
      mem_exp_t me;
      line = addr & ~32'h1F;
      set  = (addr >> 5) % SETS;
      wa   = addr >> 2;
      pos  = -1;
      for (int i = 0; i < lru[set].size(); i++) if (lru[set][i] == line) pos = i;
      ce.hit = (pos >= 0);
      if (ce.hit) begin
         lru[set].delete(pos);
         m_hits++;
      end else begin
         m_miss++;
         if (lru[set].size() == WAYS) begin
            v = lru[set].pop_back();
            if (dirty_ln.exists(v)) begin
               me.we = 1'b1; me.addr = v; me.line = vline(v);
               mem_q.push_back(me);
               dirty_ln.delete(v);
            end
         end
         me.we = 1'b0; me.addr = line; me.line = '0;
         mem_q.push_back(me);
      end
      lru[set].push_front(line);
      if (we) begin
         w = vrd(wa);
         for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
         vmem[wa] = w;
         dirty_ln[line] = 1'b1;
      end
      ce.load  = !we;
      ce.rdata = vrd(wa);
      @(negedge CLK);
      ce.issue = cyc;
      cpu_q.push_back(ce);
      cpu_req = 1'b1; cpu_we = we; cpu_be = be; cpu_addr = addr; cpu_wdata = wd;
      n = 0;
      do begin
         @(negedge CLK);
         n++;
      end while (!cpu_ready && n < 400);
      if (!cpu_ready) chk("ready_timeout", {31'b0, cpu_ready}, 32'd1);
      cpu_req = 1'b0;
      cpu_we  = 1'b0;
   endtask

   // CPU-side monitor
   always @(negedge CLK) begin
      if (RST_N && cpu_ready) begin
         if (cpu_q.size() == 0) chk("cpu_unexpected_ready", {31'b0, cpu_ready}, 32'd0);
         else begin
            cpu_exp_t e;
            int unsigned lat;
            e = cpu_q.pop_front();
            lat = cyc - e.issue;
            if (e.load) chk("load_rdata", cpu_rdata, e.rdata);
            if (e.hit) chk("hit_latency", lat, 32'd1);
            else       chk("miss_latency_gt1", {31'b0, lat > 1}, 32'd1);
         end
      end
   end

   // Memory-side monitor
   always @(negedge CLK) begin
      if (mem_req && mem_ack) begin
         if (mem_q.size() == 0) chk("mem_unexpected_xfer", {31'b0, mem_req}, 32'd0);
         else begin
            mem_exp_t e;
            e = mem_q.pop_front();
            chk("mem_we", {31'b0, mem_we}, {31'b0, e.we});
            chk("mem_addr", mem_addr, e.addr);
            if (e.we)
               for (int i = 0; i < LW; i++) chk("mem_wdata_word", mem_wdata[32*i +: 32], e.line[32*i +: 32]);
         end
      end
   end

   // Memory responder: random ack delay, one-cycle ack pulses
   always @(posedge CLK) begin
      #1;
      if (!RST_N) mem_ack = 1'b0;
      else if (mem_ack) begin
         mem_ack = 1'b0;
         dly = $urandom_range(0, 2);
      end else if (mem_req && !hold_ack) begin
         if (dly == 0) begin
            mem_ack = 1'b1;
            if (mem_we)
               for (int i = 0; i < LW; i++) pmem[(mem_addr >> 2) + i] = mem_wdata[32*i +: 32];
            else
               for (int i = 0; i < LW; i++) mem_rdata[32*i +: 32] = prd((mem_addr >> 2) + i);
         end else dly--;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned n;
      pmem[32'h100 >> 2] = 32'hA5A50001;
      pmem[32'h104 >> 2] = 32'hFFFFFFFF;

      // Refill then repeat hit; partial store merge
      do_reset();
      access(0, 4'hF, 32'h100, 0);
      access(0, 4'hF, 32'h100, 0);
`ifdef CACHE_STATS_EN
      @(negedge CLK);
      chk("hit_count", hit_count, 32'd1);
      chk("miss_count", miss_count, 32'd1);
`endif
      access(1, 4'b0011, 32'h104, 32'h12345678);
      access(0, 4'hF, 32'h104, 0);

      // LRU eviction of a clean line
      do_reset();
      access(0, 4'hF, 32'h100, 0);
      access(0, 4'hF, 32'h200, 0);
      access(0, 4'hF, 32'h100, 0);
      access(0, 4'hF, 32'h300, 0);
      access(0, 4'hF, 32'h100, 0);

      // Dirty eviction with writeback, then reload the written line
      do_reset();
      access(1, 4'hF, 32'h100, 32'hDEADBEEF);
      access(0, 4'hF, 32'h200, 0);
      access(0, 4'hF, 32'h300, 0);
      access(0, 4'hF, 32'h100, 0);

      // Reset asserted during a refill
      do_reset();
      hold_ack = 1'b1;
      @(negedge CLK);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_be = 4'hF; cpu_addr = 32'h100;
      n = 0;
      do begin
         @(negedge CLK);
         n++;
      end while (!mem_req && n < 50);
      chk("refill_req", {31'b0, mem_req}, 32'd1);
      chk("refill_we", {31'b0, mem_we}, 32'd0);
      chk("refill_addr", mem_addr, 32'h100);
      #2 RST_N = 1'b0;
      #1;
      chk("rst_abort_mem_req", {31'b0, mem_req}, 32'd0);
      chk("rst_abort_mem_addr", mem_addr, 32'd0);
      cpu_req = 1'b0;
      repeat (2) @(negedge CLK);
      model_reset();
      hold_ack = 1'b0;
      RST_N = 1'b1;
      access(0, 4'hF, 32'h100, 0);

      // Randomized traffic over a few conflicting lines
      do_reset();
      for (int k = 0; k < 400; k++) begin
         logic [31:0] a;
         a = ($urandom_range(1, 4) << 8) | ($urandom_range(0, 1) << 5) | ($urandom_range(0, 7) << 2);
         access($urandom_range(0, 1), 4'($urandom_range(0, 15)), a, $urandom);
      end
      repeat (4) @(negedge CLK);
`ifdef CACHE_STATS_EN
      chk("rand_hit_count", hit_count, m_hits);
      chk("rand_miss_count", miss_count, m_miss);
`endif
      chk("cpu_q_drained", cpu_q.size(), 32'd0);
      chk("mem_q_drained", mem_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
